// File: rtl/tqvp_spi_pkg.sv
// Register map, STATUS/CONFIG bit positions and controller state encoding
// shared by the SPI peripheral files.
package tqvp_spi_pkg;

  localparam logic [5:0] REG_DATA   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h04;
  localparam logic [5:0] REG_CONFIG = 6'h08;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_RX_VALID = 3;
  localparam int STAT_TX_OVF   = 4;
  localparam int STAT_RX_OVR   = 5;

  localparam int CFG_CPOL    = 8;
  localparam int CFG_CPHA    = 9;
  localparam int CFG_CS_AUTO = 10;
  localparam int CFG_CS_MAN  = 11;
  localparam int CFG_IE      = 12;
  localparam int CFG_LSB     = 13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } spi_state_e;

endpackage

// File: rtl/tqvp_spi_fifo.sv
// Synchronous FIFO, zero-latency read data (show-ahead). A push while full is
// accepted only when a pop happens in the same cycle; otherwise it is dropped.
module tqvp_spi_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tqvp_spi_ctrl.sv
// TinyQV SPI controller peripheral: byte TX FIFO, single RX holding byte, single-cycle reads.
// Define TQVP_SPI_LSB_FIRST_EN to make CONFIG[13] select LSB-first shifting.
module tqvp_spi_ctrl
  import tqvp_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MISO_BIT   = 2,
  parameter int DIV_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic             wr_req, rd_req, last_wr, last_rd, wr_edge, rd_edge;
  logic             wr_data, wr_status, wr_cfg, rd_pop;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_cpol, cfg_cpha, cfg_cs_auto, cfg_cs_man, cfg_ie, cfg_lsb;
  logic [7:0]       rx_byte;
  logic             rx_valid, rx_ovr, tx_ovf;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [7:0]       fifo_rdata;
  logic [31:0]      status_rd, cfg_rd;
  logic             busy, miso, sclk, mosi, cs_n;
  logic             unused_bits;

  spi_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, lat_div_q, lat_div_d;
  logic [3:0]       hp_q, hp_d;
  logic [7:0]       tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic             act_q, act_d, lat_cpol_q, lat_cpol_d, lat_cpha_q, lat_cpha_d;
  logic             lat_lsb_q, lat_lsb_d;
  logic             tick, edge_now, lead, first_edge, done_set;

  // Bus side effects fire only on the first cycle of a request.
  assign wr_req    = (data_write_n != 2'b11);
  assign rd_req    = (data_read_n != 2'b11);
  assign wr_edge   = wr_req & ~last_wr;
  assign rd_edge   = rd_req & ~last_rd;
  assign wr_data   = wr_edge & (address == REG_DATA);
  assign wr_status = wr_edge & (address == REG_STATUS);
  assign wr_cfg    = wr_edge & (address == REG_CONFIG);
  assign rd_pop    = rd_edge & (address == REG_DATA);

  assign miso        = ui_in[MISO_BIT];
  assign unused_bits = &{1'b0, ui_in, data_in};

  tqvp_spi_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_data),
    .wdata (data_in[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hp_q       <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      act_q      <= 1'b0;
      lat_div_q  <= '0;
      lat_cpol_q <= 1'b0;
      lat_cpha_q <= 1'b0;
      lat_lsb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hp_q       <= hp_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      act_q      <= act_d;
      lat_div_q  <= lat_div_d;
      lat_cpol_q <= lat_cpol_d;
      lat_cpha_q <= lat_cpha_d;
      lat_lsb_q  <= lat_lsb_d;
    end
  end

  // SHIFT half-period hp is entered by SCLK edge hp+1; odd edges are leading.
  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    act_d      = act_q;
    lat_div_d  = lat_div_q;
    lat_cpol_d = lat_cpol_q;
    lat_cpha_d = lat_cpha_q;
    lat_lsb_d  = lat_lsb_q;
    fifo_pop   = 1'b0;
    done_set   = 1'b0;
    edge_now   = 1'b0;
    lead       = 1'b0;
    first_edge = 1'b0;
    tick       = (cnt_q == lat_div_q);

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (tick) begin
          state_d    = S_SHIFT;
          hp_d       = 4'd0;
          edge_now   = 1'b1;
          lead       = 1'b1;
          first_edge = 1'b1;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (hp_q == 4'd15) begin
            state_d  = S_DONE;
            done_set = 1'b1;
          end else begin
            hp_d     = hp_q + 4'd1;
            edge_now = 1'b1;
            lead     = hp_q[0];
          end
        end
      end
      S_DONE: begin
        if (tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = S_LOAD;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = (tick || state_q == S_IDLE) ? '0 : cnt_q + DIV_W'(1);

    if (fifo_pop) begin
      tx_sr_d    = fifo_rdata;
      rx_sr_d    = '0;
      act_d      = 1'b0;
      lat_div_d  = cfg_div;
      lat_cpol_d = cfg_cpol;
      lat_cpha_d = cfg_cpha;
      lat_lsb_d  = cfg_lsb;
    end

    // The first leading edge never shifts: MOSI already carries bit 0 of the frame.
    if (edge_now) begin
      act_d = ~act_q;
      if (lead ^ lat_cpha_q)
        rx_sr_d = lat_lsb_q ? {miso, rx_sr_q[7:1]} : {rx_sr_q[6:0], miso};
      else if (!first_edge)
        tx_sr_d = lat_lsb_q ? {1'b0, tx_sr_q[7:1]} : {tx_sr_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr     <= 1'b0;
      last_rd     <= 1'b0;
      cfg_div     <= '0;
      cfg_cpol    <= 1'b0;
      cfg_cpha    <= 1'b0;
      cfg_cs_auto <= 1'b0;
      cfg_cs_man  <= 1'b0;
      cfg_ie      <= 1'b0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      rx_ovr      <= 1'b0;
      tx_ovf      <= 1'b0;
    end else begin
      last_wr <= wr_req;
      last_rd <= rd_req;
      if (wr_cfg) begin
        cfg_div     <= data_in[DIV_W-1:0];
        cfg_cpol    <= data_in[CFG_CPOL];
        cfg_cpha    <= data_in[CFG_CPHA];
        cfg_cs_auto <= data_in[CFG_CS_AUTO];
        cfg_cs_man  <= data_in[CFG_CS_MAN];
        cfg_ie      <= data_in[CFG_IE];
      end
      if (done_set) rx_byte <= rx_sr_q;
      rx_valid <= done_set | (rx_valid & ~rd_pop);
      // Set events take priority over a coincident write-1-to-clear.
      rx_ovr <= (done_set & rx_valid & ~rd_pop) | (rx_ovr & ~(wr_status & data_in[STAT_RX_OVR]));
      tx_ovf <= (wr_data & fifo_full & ~fifo_pop) | (tx_ovf & ~(wr_status & data_in[STAT_TX_OVF]));
    end
  end

`ifdef TQVP_SPI_LSB_FIRST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cfg_lsb <= 1'b0;
    else if (wr_cfg) cfg_lsb <= data_in[CFG_LSB];
  end
`else
  assign cfg_lsb = 1'b0;
`endif

  assign busy = (state_q != S_IDLE);
  assign sclk = (state_q == S_IDLE) ? cfg_cpol : (lat_cpol_q ^ act_q);
  assign mosi = busy & (lat_lsb_q ? tx_sr_q[0] : tx_sr_q[7]);
  assign cs_n = cfg_cs_auto ? ~busy : ~cfg_cs_man;

  assign uo_out         = {3'b000, cs_n, mosi, sclk, 2'b00};
  assign data_ready     = 1'b1;
  assign user_interrupt = cfg_ie & ((fifo_empty & ~busy) | rx_ovr | tx_ovf);

  always_comb begin
    status_rd                = '0;
    status_rd[STAT_BUSY]     = busy;
    status_rd[STAT_TX_FULL]  = fifo_full;
    status_rd[STAT_TX_EMPTY] = fifo_empty;
    status_rd[STAT_RX_VALID] = rx_valid;
    status_rd[STAT_TX_OVF]   = tx_ovf;
    status_rd[STAT_RX_OVR]   = rx_ovr;

    cfg_rd              = '0;
    cfg_rd[DIV_W-1:0]   = cfg_div;
    cfg_rd[CFG_CPOL]    = cfg_cpol;
    cfg_rd[CFG_CPHA]    = cfg_cpha;
    cfg_rd[CFG_CS_AUTO] = cfg_cs_auto;
    cfg_rd[CFG_CS_MAN]  = cfg_cs_man;
    cfg_rd[CFG_IE]      = cfg_ie;
    cfg_rd[CFG_LSB]     = cfg_lsb;

    data_out = '0;
    case (address)
      REG_DATA:   data_out = {24'h0, rx_byte};
      REG_STATUS: data_out = status_rd;
      REG_CONFIG: data_out = cfg_rd;
      default:    data_out = '0;
    endcase
  end

endmodule
